counter_bank: RTL
=================

COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent counter channels, range 1..16.
REQ-002 Parameter WIDTH, default 8: counter width per channel in bits, range 2..32.
REQ-003 Parameter DIV_WIDTH, default 24: prescaler width in bits.
REQ-004 sys_clk  in  1: the only clock; all logic on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 div_reload  in  DIV_WIDTH: prescaler reload value; tick period is div_reload+1 cycles.
REQ-007 ch_clear  in  N_CH: per-channel level; count forced to 0.
REQ-008 ch_disable  in  N_CH: per-channel level; blocks tick-driven counting only.
REQ-009 ch_auto  in  N_CH: per-channel level; counting on the prescaler tick is enabled.
REQ-010 ch_dir  in  N_CH: per-channel tick direction (0 = up, 1 = down).
REQ-011 ch_sat  in  N_CH: per-channel overflow mode (0 = wrap, 1 = saturate).
REQ-012 ch_up, ch_down  in  N_CH each: per-channel single-cycle step pulses (trigger-in style).
REQ-013 ch_load  in  N_CH, load_val  in  N_CH*WIDTH: per-channel pulse that loads the matching load_val slice.
REQ-014 cmp_val  in  N_CH*WIDTH: per-channel compare value.
REQ-015 count  out  N_CH*WIDTH: registered counter values; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-016 cmp_pulse, zero_pulse, ovf_pulse  out  N_CH each: per-channel single-cycle event pulses.
REQ-017 tick  out  1: prescaler tick, one cycle high per period.

Function
REQ-018 Prescaler: a down-counter; when it reaches 0 it reloads div_reload and asserts tick on the following cycle only; with div_reload=0, tick is high on every cycle after reset.
REQ-019 A div_reload change takes effect at the next reload, not mid-period.
REQ-020 Per-channel update priority, one action per cycle: clear > load > (up XOR down) > tick.
REQ-021 The tick action applies only when ch_auto=1, ch_disable=0 and tick=1; ch_dir sets its direction.
REQ-022 ch_up and ch_down asserted in the same cycle cancel: no step from the pulses, and the tick action for that cycle is also suppressed.
REQ-023 Wrap mode: a step up from all-ones gives 0 and a step down from 0 gives all-ones; ovf_pulse asserts one cycle later.
REQ-024 Saturate mode: the count holds at all-ones going up and at 0 going down; ovf_pulse asserts one cycle later on each blocked step.
REQ-025 cmp_pulse asserts for one cycle, one cycle after count transitions into equality with cmp_val. It does not re-fire while equality holds.
REQ-026 cmp_pulse also fires if cmp_val changes to equal a held count.
REQ-027 zero_pulse follows the same edge rule as cmp_pulse, applied to count==0; it includes entering 0 through clear or load.
REQ-028 The count output updates on the cycle after the action (1-cycle latency); event pulses lag count by exactly one cycle.
REQ-029 Channels are fully independent; only the prescaler is shared.

Reset
REQ-030 While reset=1 on a sys_clk edge: all counts = 0, prescaler = div_reload, all pulse outputs = 0, tick = 0, equality history = "equal" for both compare detectors.
REQ-031 Consequence of REQ-030: no zero_pulse or cmp_pulse fires as a direct result of reset.
REQ-032 A reset asserted mid-period or mid-step discards the pending action; the first tick comes div_reload+1 cycles after reset deasserts.

Structure
REQ-033 Package counter_bank_pkg holds the direction and overflow-mode constants and the default parameter values.
REQ-034 Sub-module counter_bank_ch implements one channel (REQ-020..REQ-028); it is instantiated N_CH times in a generate loop, and the prescaler lives in the top level.
REQ-035 No latches and no derived clocks; the tick is a clock enable only.

Verification
REQ-036 Scenario 1, prescaler: div_reload=3 -> tick every 4th cycle; change div_reload to 1 mid-period -> old period completes, then tick every 2nd cycle.
REQ-037 Scenario 2, wrap: WIDTH=8, ch_auto=1, dir=up, wrap, starting at 0xFE -> counts 0xFF, 0x00; ovf_pulse and zero_pulse 1 cycle after count reaches 0x00.
REQ-038 Scenario 3, saturate: dir=down from 0x01, ch_sat=1 -> count 0x00 and holds; ovf_pulse on each later tick; zero_pulse once.
REQ-039 Scenario 4, priority: ch_clear+ch_load+ch_up in the same cycle -> count 0; ch_up+ch_down at value 0x10 on a tick cycle -> stays 0x10.
REQ-040 Scenario 5, compare: cmp_val=0x80, load 0x7F then ch_up -> cmp_pulse exactly once; further ticks with ch_disable=1 -> no further pulse.
REQ-041 Scenario 6, reset mid-operation: reset during counting on channel 2 (N_CH=4) -> all counts 0, no pulses; resumes cleanly after reset deasserts.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared constants for the counter bank: direction and overflow-mode encodings
// plus the default sizing of the bank.
package counter_bank_pkg;

  localparam int N_CH_DEF      = 4;
  localparam int WIDTH_DEF     = 8;
  localparam int DIV_WIDTH_DEF = 24;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic OVF_WRAP = 1'b0;
  localparam logic OVF_SAT  = 1'b1;

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: prioritised update (clear > load > step pulses > tick),
// wrap/saturate overflow handling and edge-detected compare/zero events.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic             dis,
  input  logic             auto_en,
  input  logic             dir,
  input  logic             sat,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             cmp_pulse,
  output logic             zero_pulse,
  output logic             ovf_pulse
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // MSB flags a step that hit the range edge; low bits are the resulting value
  function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] v,
                                             input logic             dn,
                                             input logic             sat_mode);
    logic             edge_hit;
    logic [WIDTH-1:0] nxt;
    edge_hit = dn ? (v == '0) : (v == ALL_ONES);
    if (edge_hit && sat_mode) nxt = v;
    else if (dn)              nxt = v - ONE;
    else                      nxt = v + ONE;
    return {edge_hit, nxt};
  endfunction

  logic             tick_act;
  logic             step_req;
  logic             step_dn;
  logic [WIDTH:0]   stepped;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;

  // Simultaneous up/down cancel each other and also swallow this cycle's tick
  always_comb begin
    tick_act = tick && auto_en && !dis && !(up && down);
    step_req = (up ^ down) || tick_act;
    step_dn  = (up ^ down) ? down : (dir == DIR_DOWN);
    stepped  = step_fn(count, step_dn, sat == OVF_SAT);
    cnt_nxt  = count;
    ovf_nxt  = 1'b0;
    if (clear) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = load_val;
    end else if (step_req) begin
      cnt_nxt = stepped[WIDTH-1:0];
      ovf_nxt = stepped[WIDTH];
    end
  end

  logic ovf_p0;
  logic cmp_eq_p1;
  logic zero_eq_p1;

  // Stage p0: count and raw overflow; stage p1: event pulses, one cycle behind count
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count      <= '0;
      ovf_p0     <= 1'b0;
      cmp_eq_p1  <= 1'b1;
      zero_eq_p1 <= 1'b1;
      cmp_pulse  <= 1'b0;
      zero_pulse <= 1'b0;
      ovf_pulse  <= 1'b0;
    end else begin
      count      <= cnt_nxt;
      ovf_p0     <= ovf_nxt;
      cmp_eq_p1  <= (count == cmp_val);
      zero_eq_p1 <= (count == '0);
      cmp_pulse  <= (count == cmp_val) && !cmp_eq_p1;
      zero_pulse <= (count == '0) && !zero_eq_p1;
      ovf_pulse  <= ovf_p0;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH independent counters sharing one reloadable prescaler whose
// tick acts purely as a clock enable for the channels.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [DIV_WIDTH-1:0]    div_reload,
  input  logic [N_CH-1:0]         ch_clear,
  input  logic [N_CH-1:0]         ch_disable,
  input  logic [N_CH-1:0]         ch_auto,
  input  logic [N_CH-1:0]         ch_dir,
  input  logic [N_CH-1:0]         ch_sat,
  input  logic [N_CH-1:0]         ch_up,
  input  logic [N_CH-1:0]         ch_down,
  input  logic [N_CH-1:0]         ch_load,
  input  logic [N_CH*WIDTH-1:0]   load_val,
  input  logic [N_CH*WIDTH-1:0]   cmp_val,
  output logic [N_CH*WIDTH-1:0]   count,
  output logic [N_CH-1:0]         cmp_pulse,
  output logic [N_CH-1:0]         zero_pulse,
  output logic [N_CH-1:0]         ovf_pulse,
  output logic                    tick
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_cnt;

  // div_reload is only sampled on reload, so a change never cuts a period short
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div_cnt <= div_reload;
      tick    <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= div_reload;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt - DIV_ONE;
      tick    <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_bank_ch #(.WIDTH(WIDTH)) u_ch (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .tick       (tick),
      .clear      (ch_clear[i]),
      .dis        (ch_disable[i]),
      .auto_en    (ch_auto[i]),
      .dir        (ch_dir[i]),
      .sat        (ch_sat[i]),
      .up         (ch_up[i]),
      .down       (ch_down[i]),
      .load       (ch_load[i]),
      .load_val   (load_val[i*WIDTH +: WIDTH]),
      .cmp_val    (cmp_val[i*WIDTH +: WIDTH]),
      .count      (count[i*WIDTH +: WIDTH]),
      .cmp_pulse  (cmp_pulse[i]),
      .zero_pulse (zero_pulse[i]),
      .ovf_pulse  (ovf_pulse[i])
    );
  end

endmodule
